// File: rtl/id_scoreboard_ctrl.sv
// ID-stage scoreboard and hazard controller: tracks pending register writes,
// stalls dependent instructions, and sequences flush bubbles.
module id_scoreboard_ctrl #(
    parameter int unsigned FLUSH_LEN = 1,
    parameter int unsigned MAX_STALL = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] instr,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic        flush_req,
    output logic        stall,
    output logic        bubble,
    output logic        issue,
    output logic [31:0] busy_vec,
    output logic [1:0]  state,
    output logic [7:0]  stall_cnt,
    output logic        err
);

    localparam int unsigned NREG   = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FCNT_W = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [NREG-1:0]     busy_vec_q, busy_vec_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                err_q, err_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, dst;
    logic       use_rs, use_rt, has_dst;
    logic       hazard;
    logic       unused_instr_bits;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign unused_instr_bits = ^instr[10:0];

    // Operand decode by opcode class
    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        has_dst = 1'b0;
        dst     = 5'd0;
        case (opcode)
            6'b000000: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                has_dst = 1'b1;
                dst     = rd;
            end
            6'b100011, 6'b001000: begin
                use_rs  = 1'b1;
                has_dst = 1'b1;
                dst     = rt;
            end
            6'b101011, 6'b000100: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // No bypass: a same-cycle writeback does not hide the hazard
    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            if (use_rs && (rs != 5'd0) && busy_vec_q[rs]) hazard = 1'b1;
            if (use_rt && (rt != 5'd0) && busy_vec_q[rt]) hazard = 1'b1;
        end
    end

    // Pipeline control; flush and reset force a bubble with no stall
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b1;
        issue  = 1'b0;
        if (reset && !flush_req && (state_q != ST_FLUSH)) begin
            stall  = hazard;
            bubble = hazard;
            issue  = id_valid && !hazard;
        end
    end

    // Next-state for scoreboard, FSM, counters
    always_comb begin
        busy_vec_d  = busy_vec_q;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = 8'd0;
        err_d       = err_q;

        if (wb_reg_write && (wb_write_reg != 5'd0)) begin
            busy_vec_d[wb_write_reg] = 1'b0;
        end
        if (issue && has_dst && (dst != 5'd0)) begin
            busy_vec_d[dst] = 1'b1;
        end
        busy_vec_d[0] = 1'b0;

        if (flush_req) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN:   if (hazard) state_d = ST_STALL;
                ST_STALL: if (!hazard) state_d = ST_RUN;
                ST_FLUSH: begin
                    if ((32'(flush_cnt_q) + 32'd1) >= FLUSH_LEN) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 2'd1;
                    end
                end
                default:  state_d = ST_RUN;
            endcase
        end

        if (stall) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
            if (32'(stall_cnt_q) >= (MAX_STALL - 32'd1)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_vec_q  <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_vec_q  <= busy_vec_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    assign busy_vec  = busy_vec_q;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Testbench for id_scoreboard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the scoreboard.
module tb_id_scoreboard_ctrl;

    localparam int unsigned FLUSH_LEN = 1;
    localparam int unsigned MAX_STALL = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] instr;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic        flush_req;
    logic        stall, bubble, issue;
    logic [31:0] busy_vec;
    logic [1:0]  state;
    logic [7:0]  stall_cnt;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending-write set, phase (0 RUN, 1 STALL, 2 FLUSH)
    bit pending[32];
    int m_phase;
    int m_flush_done;
    int m_stall_run;
    bit m_err;

    id_scoreboard_ctrl #(.FLUSH_LEN(FLUSH_LEN), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .instr(instr),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .flush_req(flush_req), .stall(stall), .bubble(bubble), .issue(issue),
        .busy_vec(busy_vec), .state(state), .stall_cnt(stall_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sources/destination of an instruction; -1 means none
    function automatic void decode(input logic [31:0] i, output int sa, output int sb, output int d);
        int op;
        op = int'(i[31:26]);
        sa = -1; sb = -1; d = -1;
        case (op)
            'h00: begin sa = int'(i[25:21]); sb = int'(i[20:16]); d = int'(i[15:11]); end
            'h23, 'h08: begin sa = int'(i[25:21]); d = int'(i[20:16]); end
            'h2B, 'h04: begin sa = int'(i[25:21]); sb = int'(i[20:16]); end
            default: ;
        endcase
    endfunction

    function automatic bit is_pending(input int r);
        return (r > 0) && pending[r];
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = (r != 0) && pending[r];
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) pending[r] = 1'b0;
        m_phase = 0; m_flush_done = 0; m_stall_run = 0; m_err = 1'b0;
    endtask

    // One clock: drive, check combinational controls, advance model, check registers
    task automatic cycle(input logic rst_i, input logic vld, input logic [31:0] ins,
                         input logic wbw, input logic [4:0] wbr, input logic fl);
        int  sa, sb, d;
        bit  hz, e_stall, e_bubble, e_issue;
        reset = rst_i; id_valid = vld; instr = ins;
        wb_reg_write = wbw; wb_write_reg = wbr; flush_req = fl;
        #2;
        decode(ins, sa, sb, d);
        hz = vld && (is_pending(sa) || is_pending(sb));
        if (!rst_i || fl || m_phase == 2) begin
            e_stall = 0; e_bubble = 1; e_issue = 0;
        end else begin
            e_stall = hz; e_bubble = hz; e_issue = vld && !hz;
        end
        check_eq("stall", 32'(stall), 32'(e_stall));
        check_eq("bubble", 32'(bubble), 32'(e_bubble));
        check_eq("issue", 32'(issue), 32'(e_issue));
        @(posedge clk);
        if (!rst_i) begin
            model_clear();
        end else begin
            if (wbw && wbr != 0) pending[int'(wbr)] = 1'b0;
            if (e_issue && d > 0) pending[d] = 1'b1;
            if (e_stall && m_stall_run >= int'(MAX_STALL) - 1) m_err = 1'b1;
            m_stall_run = e_stall ? ((m_stall_run < 255) ? m_stall_run + 1 : 255) : 0;
            if (fl) begin
                m_phase = 2; m_flush_done = 0;
            end else if (m_phase == 2) begin
                m_flush_done++;
                if (m_flush_done >= int'(FLUSH_LEN)) begin m_phase = 0; m_flush_done = 0; end
            end else begin
                m_phase = hz ? 1 : 0;
            end
        end
        #1;
        check_eq("busy_vec", busy_vec, model_busy());
        check_eq("state", 32'(state), 32'(m_phase));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall_run));
        check_eq("err", 32'(err), 32'(m_err));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [8];
        logic [31:0] v;
        logic [4:0]  a, b, c;
        ops[0] = 6'h00; ops[1] = 6'h00; ops[2] = 6'h23; ops[3] = 6'h08;
        ops[4] = 6'h2B; ops[5] = 6'h04; ops[6] = 6'h02; ops[7] = 6'h3F;
        a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        b = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        c = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        v = {ops[$urandom_range(0, 7)], a, b, c, 11'($urandom)};
        return v;
    endfunction

    localparam logic [31:0] LW8     = 32'h8C08_0000;
    localparam logic [31:0] ADD988  = 32'h0108_4820;
    localparam logic [31:0] ADD012  = 32'h0022_0020;
    localparam logic [31:0] SUB300  = 32'h0000_1822;
    localparam logic [31:0] ADDI5   = 32'h2005_0000;
    localparam logic [31:0] ADD655  = 32'h00A5_3020;

    initial begin
        reset = 1'b0; id_valid = 1'b0; instr = '0;
        wb_reg_write = 1'b0; wb_write_reg = '0; flush_req = 1'b0;
        model_clear();
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        cycle(1'b0, 1'b1, ADD012, 1'b0, 5'd0, 1'b0);
        check_eq("rst_busy", busy_vec, 32'h0);

        // Load-use hazard resolved by writeback
        cycle(1'b1, 1'b1, LW8, 1'b0, 5'd0, 1'b0);
        check_eq("lw_busy", busy_vec, 32'h0000_0100);
        cycle(1'b1, 1'b1, ADD988, 1'b0, 5'd0, 1'b0);
        check_eq("lu_state", 32'(state), 32'd1);
        cycle(1'b1, 1'b1, ADD988, 1'b1, 5'd8, 1'b0);
        cycle(1'b1, 1'b1, ADD988, 1'b0, 5'd0, 1'b0);
        check_eq("lu_issued_busy", busy_vec, 32'h0000_0200);

        // $0 destination never tracked
        cycle(1'b1, 1'b1, ADD012, 1'b1, 5'd9, 1'b0);
        cycle(1'b1, 1'b1, SUB300, 1'b0, 5'd0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 1'b0);
        check_eq("r0_busy", busy_vec, 32'h0);

        // Set beats clear on the same register
        cycle(1'b1, 1'b1, ADDI5, 1'b1, 5'd5, 1'b0);
        check_eq("setwin_busy", busy_vec, 32'h0000_0020);

        // Flush over a pending hazard
        cycle(1'b1, 1'b1, ADD655, 1'b0, 5'd0, 1'b1);
        check_eq("fl_state", 32'(state), 32'd2);
        cycle(1'b1, 1'b1, ADD655, 1'b0, 5'd0, 1'b0);
        check_eq("fl_done_state", 32'(state), 32'd0);
        check_eq("fl_busy", busy_vec, 32'h0000_0020);

        // Long stall raises sticky err
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b1, ADD655, 1'b0, 5'd0, 1'b0);
            if (i == 15) check_eq("err_before", 32'(err), 32'd0);
            if (i == 16) check_eq("err_rise", 32'(err), 32'd1);
        end
        check_eq("long_stall_cnt", 32'(stall_cnt), 32'd20);
        check_eq("long_err", 32'(err), 32'd1);

        // Reset mid-STALL with a full scoreboard
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        for (int r = 1; r < 32; r++) cycle(1'b1, 1'b1, ADDI5 & 32'hFFE0_FFFF | (32'(r) << 16), 1'b0, 5'd0, 1'b0);
        cycle(1'b1, 1'b1, ADD655, 1'b0, 5'd0, 1'b0);
        check_eq("full_busy", busy_vec, 32'hFFFF_FFFE);
        check_eq("full_state", 32'(state), 32'd1);
        cycle(1'b0, 1'b1, ADD655, 1'b0, 5'd0, 1'b0);
        check_eq("post_rst_busy", busy_vec, 32'h0);
        check_eq("post_rst_state", 32'(state), 32'd0);
        check_eq("post_rst_err", 32'(err), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  rand_instr(),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom),
                  ($urandom_range(0, 11) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scoreboard_ctrl.md
ID_SCOREBOARD_CTRL -- requirements
Module: id_scoreboard_ctrl

Interface
REQ-001 Parameter FLUSH_LEN, default 1, bubble cycles inserted after a flush (legal 1..3).
REQ-002 Parameter MAX_STALL, default 16, consecutive stall cycles before err is raised (legal 2..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 id_valid  input  1  IF/ID latch holds a valid instruction.
REQ-006 instr  input  32  instruction in IF/ID latch.
REQ-007 wb_reg_write  input  1  WB stage writes register file this cycle.
REQ-008 wb_write_reg  input  5  WB destination register.
REQ-009 flush_req  input  1  taken branch/jump resolved in EX; younger instructions are dead.
REQ-010 stall  output  1  hold PC and IF/ID latch.
REQ-011 bubble  output  1  force ID/EX control bits to zero this cycle.
REQ-012 issue  output  1  instruction in ID advances into ID/EX this cycle.
REQ-013 busy_vec  output  32  pending-write scoreboard, bit n = register n awaiting writeback.
REQ-014 state  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-015 stall_cnt  output  8  consecutive stall cycles, saturating at 255.
REQ-016 err  output  1  sticky; stall has lasted MAX_STALL cycles.

Function
REQ-017 Decode SHALL use instr[31:26]: 000000 R-type (src rs, rt; dst [15:11]); 100011 lw and 001000 addi (src rs; dst [20:16]); 101011 sw and 000100 beq (src rs, rt; no dst); 000010 j (no src, no dst); any other opcode has no src and no dst.
REQ-018 hazard SHALL be 1 when id_valid=1 and any source register of the decoded instruction has its busy_vec bit set; register 0 is never a hazard.
REQ-019 In RUN or STALL with flush_req=0: stall=hazard, bubble=hazard, issue=id_valid AND NOT hazard.
REQ-020 On issue with a destination register other than 0, that busy_vec bit SHALL be set at the next edge.
REQ-021 When wb_reg_write=1 and wb_write_reg!=0, that busy_vec bit SHALL clear at the next edge; a clear does not remove a hazard in the same cycle (no bypass).
REQ-022 When set and clear hit the same register in the same cycle, set SHALL win.
REQ-023 busy_vec[0] SHALL always read 0.
REQ-024 FSM transitions: RUN->STALL when hazard=1; STALL->RUN when hazard=0; any state->FLUSH when flush_req=1; FLUSH->RUN after FLUSH_LEN cycles in FLUSH with flush_req=0.
REQ-025 flush_req=1 SHALL take priority over hazard: that cycle issue=0, bubble=1, stall=0 (IF/ID is reloaded by the fetch stage).
REQ-026 In FLUSH: issue=0, bubble=1, stall=0; flush_req=1 while in FLUSH restarts the FLUSH_LEN count.
REQ-027 flush SHALL NOT modify busy_vec; WB clears continue during FLUSH.
REQ-028 stall_cnt SHALL increment each cycle stall=1, saturate at 255, and clear to 0 on any cycle stall=0.
REQ-029 err SHALL set when stall_cnt reaches MAX_STALL-1 with stall=1, and hold until reset.
REQ-030 stall, bubble and issue are combinational from state, inputs and busy_vec; busy_vec, state, stall_cnt and err are registers.

Reset
REQ-031 With reset=0 at an edge: busy_vec=0, state=RUN, stall_cnt=0, err=0, FLUSH count=0.
REQ-032 While reset=0: issue=0, stall=0, bubble=1.
REQ-033 Reset asserted mid-STALL or mid-FLUSH SHALL discard all state; the first cycle after reset is RUN with an empty scoreboard.

Verification
REQ-034 Issue lw $8 (0x8C080000), then add $9,$8,$8 -> add cycle: stall=1, bubble=1, state goes to STALL, busy_vec=0x00000100; WB of $8 -> add issues on the following cycle.
REQ-035 Issue add $0,$1,$2 then sub using $0 -> busy_vec stays 0, no stall.
REQ-036 Same cycle: issue writes $5 and WB clears $5 -> busy_vec[5]=1 afterwards.
REQ-037 Hazard pending plus flush_req=1 -> issue=0, bubble=1, state=FLUSH for FLUSH_LEN=1 cycle, then RUN; busy_vec unchanged.
REQ-038 Hold hazard with no WB for 20 cycles, MAX_STALL=16 -> err rises on cycle 16 and stays 1; stall_cnt reads 20.
REQ-039 Apply reset=0 in STALL with busy_vec=0xFFFFFFFE -> next cycle busy_vec=0, state=RUN, err=0.
